// File: rtl/ysyx_rob_ctrl_if.sv
// ROB control bus: dispatch allocation, writeback completion, commit retirement and flush.
// master: rename/execute/commit side (drives requests, observes status).
// slave : the ROB controller (ysyx_rob_ctrl).
interface ysyx_rob_ctrl_if #(
   parameter int unsigned ROB_SIZE = 8,
   parameter int unsigned XLEN     = 32,
   parameter int unsigned RLEN     = 5,
   parameter int unsigned PLEN     = 6
);
   localparam int unsigned IDXW = $clog2(ROB_SIZE);

   // Dispatch
   logic            disp_valid;
   logic            disp_ready;
   logic [RLEN-1:0] disp_rd;
   logic [PLEN-1:0] disp_prd;
   logic [PLEN-1:0] disp_prs;
   logic [IDXW-1:0] disp_idx;
   // Writeback
   logic            wb_valid;
   logic [IDXW-1:0] wb_idx;
   logic            wb_mispred;
   logic [XLEN-1:0] wb_npc;
   // Commit
   logic            cm_valid;
   logic            cm_ready;
   logic [IDXW-1:0] cm_idx;
   logic [RLEN-1:0] cm_rd;
   logic [PLEN-1:0] cm_prd;
   logic [PLEN-1:0] cm_prs;
   // Flush / status
   logic            flush;
   logic [XLEN-1:0] flush_npc;
   logic [IDXW:0]   count;

   modport master (
      output disp_valid, disp_rd, disp_prd, disp_prs,
      output wb_valid, wb_idx, wb_mispred, wb_npc,
      output cm_ready,
      input  disp_ready, disp_idx, cm_valid, cm_idx, cm_rd, cm_prd, cm_prs,
      input  flush, flush_npc, count
   );

   modport slave (
      input  disp_valid, disp_rd, disp_prd, disp_prs,
      input  wb_valid, wb_idx, wb_mispred, wb_npc,
      input  cm_ready,
      output disp_ready, disp_idx, cm_valid, cm_idx, cm_rd, cm_prd, cm_prs,
      output flush, flush_npc, count
   );
endinterface

// File: rtl/ysyx_rob_ctrl.sv
// Reorder-buffer control: head/tail pointers, occupancy, per-entry state and mapping fields.
// Ports: clock (rising edge), reset (async, active-high), bus (ysyx_rob_ctrl_if.slave) carrying
// dispatch allocation, writeback completion, in-order commit and the mispredict flush.
module ysyx_rob_ctrl #(
   parameter int unsigned ROB_SIZE = 8,
   parameter int unsigned XLEN     = 32,
   parameter int unsigned RLEN     = 5,
   parameter int unsigned PLEN     = 6
) (
   input logic           clock,
   input logic           reset,
   ysyx_rob_ctrl_if.slave bus
);
   localparam int unsigned IDXW = $clog2(ROB_SIZE);

   typedef enum logic [1:0] {
      ROB_CM = 2'd0,
      ROB_EX = 2'd1,
      ROB_WB = 2'd2
   } rob_state_t;

   rob_state_t        state_q   [ROB_SIZE];
   logic [RLEN-1:0]   rd_q      [ROB_SIZE];
   logic [PLEN-1:0]   prd_q     [ROB_SIZE];
   logic [PLEN-1:0]   prs_q     [ROB_SIZE];
   logic [XLEN-1:0]   npc_q     [ROB_SIZE];
   logic [ROB_SIZE-1:0] mispred_q;

   logic [IDXW-1:0]   head_q, tail_q;
   logic [IDXW:0]     count_q;
   logic              flush_q;
   logic [XLEN-1:0]   flush_npc_q;

   logic disp_ready, cm_valid, disp_fire, cm_fire, wb_take, flush_req;

   always_comb begin
      disp_ready = (count_q != (IDXW+1)'(ROB_SIZE)) && !flush_q;
      cm_valid   = (count_q != '0) && (state_q[head_q] == ROB_WB) && !flush_q;
      disp_fire  = bus.disp_valid && disp_ready;
      cm_fire    = cm_valid && bus.cm_ready;
      // Only an in-flight (executing) entry may complete; stale writebacks are dropped.
      wb_take    = bus.wb_valid && !flush_q && (state_q[bus.wb_idx] == ROB_EX);
      flush_req  = cm_fire && mispred_q[head_q];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ROB_SIZE; i++) begin
            state_q[i] <= ROB_CM;
            rd_q[i]    <= '0;
            prd_q[i]   <= '0;
            prs_q[i]   <= '0;
            npc_q[i]   <= '0;
         end
         mispred_q   <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         flush_q     <= 1'b0;
         flush_npc_q <= '0;
      end else if (flush_req) begin
         // Mispredicted retire squashes everything younger, including same-edge dispatch.
         for (int i = 0; i < ROB_SIZE; i++) begin
            state_q[i] <= ROB_CM;
         end
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         flush_q     <= 1'b1;
         flush_npc_q <= npc_q[head_q];
      end else begin
         flush_q <= 1'b0;
         if (disp_fire) begin
            state_q[tail_q]   <= ROB_EX;
            rd_q[tail_q]      <= bus.disp_rd;
            prd_q[tail_q]     <= bus.disp_prd;
            prs_q[tail_q]     <= bus.disp_prs;
            mispred_q[tail_q] <= 1'b0;
            tail_q            <= tail_q + 1'b1;
         end
         if (wb_take) begin
            state_q[bus.wb_idx]   <= ROB_WB;
            mispred_q[bus.wb_idx] <= bus.wb_mispred;
            npc_q[bus.wb_idx]     <= bus.wb_npc;
         end
         if (cm_fire) begin
            state_q[head_q] <= ROB_CM;
            head_q          <= head_q + 1'b1;
         end
         unique case ({disp_fire, cm_fire})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign bus.disp_ready = disp_ready;
   assign bus.disp_idx   = tail_q;
   assign bus.cm_valid   = cm_valid;
   assign bus.cm_idx     = head_q;
   assign bus.cm_rd      = rd_q[head_q];
   assign bus.cm_prd     = prd_q[head_q];
   assign bus.cm_prs     = prs_q[head_q];
   assign bus.flush      = flush_q;
   assign bus.flush_npc  = flush_npc_q;
   assign bus.count      = count_q;
endmodule

// File: tb/tb_ysyx_rob_ctrl.sv
// Directed self-checking bench for ysyx_rob_ctrl (ROB_SIZE=8). Inputs change and outputs are
// checked on the falling clock edge; state updates on the rising edge.
module tb_ysyx_rob_ctrl;
   localparam int unsigned ROB_SIZE = 8;
   localparam int unsigned XLEN     = 32;
   localparam int unsigned RLEN     = 5;
   localparam int unsigned PLEN     = 6;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clock = ~clock;

   ysyx_rob_ctrl_if #(.ROB_SIZE(ROB_SIZE), .XLEN(XLEN), .RLEN(RLEN), .PLEN(PLEN)) bus ();

   ysyx_rob_ctrl #(.ROB_SIZE(ROB_SIZE), .XLEN(XLEN), .RLEN(RLEN), .PLEN(PLEN)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      bus.disp_valid = 1'b0;
      bus.wb_valid   = 1'b0;
      bus.cm_ready   = 1'b0;
      bus.wb_mispred = 1'b0;
   endtask

   task automatic dispatch(input int rd, input int prd, input int prs);
      bus.disp_valid = 1'b1;
      bus.disp_rd    = RLEN'(rd);
      bus.disp_prd   = PLEN'(prd);
      bus.disp_prs   = PLEN'(prs);
   endtask

   task automatic writeback(input int idx, input logic mp, input logic [XLEN-1:0] npc);
      bus.wb_valid   = 1'b1;
      bus.wb_idx     = 3'(idx);
      bus.wb_mispred = mp;
      bus.wb_npc     = npc;
   endtask

   task automatic do_reset();
      tick();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      idle_inputs();
      bus.disp_rd = '0; bus.disp_prd = '0; bus.disp_prs = '0;
      bus.wb_idx  = '0; bus.wb_npc   = '0;

      // Reset then idle
      tick(); tick();
      reset = 1'b0;
      tick();
      chk("rst_disp_ready", bus.disp_ready, 1);
      chk("rst_cm_valid",   bus.cm_valid,   0);
      chk("rst_count",      bus.count,      0);
      chk("rst_flush",      bus.flush,      0);
      chk("rst_flush_npc",  bus.flush_npc,  0);
      chk("rst_disp_idx",   bus.disp_idx,   0);
      chk("rst_cm_idx",     bus.cm_idx,     0);

      // Fill: 8 back-to-back dispatches
      for (int i = 0; i < 8; i++) begin
         chk("fill_disp_idx",   bus.disp_idx,   i);
         chk("fill_disp_ready", bus.disp_ready, 1);
         dispatch(i, i + 8, i + 16);
         tick();
      end
      idle_inputs();
      chk("full_count", bus.count, 8);
      chk("full_disp_ready", bus.disp_ready, 0);
      writeback(0, 1'b0, 32'h0);
      tick();
      idle_inputs();
      chk("full_cm_valid", bus.cm_valid, 1);
      chk("full_cm_prs",   bus.cm_prs,   16);
      bus.cm_ready = 1'b1;
      chk("full_commit_cycle_ready", bus.disp_ready, 0);
      tick();
      idle_inputs();
      chk("after_commit_count", bus.count, 7);
      chk("after_commit_ready", bus.disp_ready, 1);
      chk("after_commit_head",  bus.cm_idx, 1);

      // Out-of-order completion
      do_reset();
      for (int i = 0; i < 3; i++) begin
         dispatch(i + 1, i + 40, i + 30);
         tick();
      end
      idle_inputs();
      writeback(2, 1'b0, 32'h0);
      tick();
      chk("ooo_wait2", bus.cm_valid, 0);
      writeback(1, 1'b0, 32'h0);
      tick();
      chk("ooo_wait1", bus.cm_valid, 0);
      writeback(0, 1'b0, 32'h0);
      tick();
      idle_inputs();
      bus.cm_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("ooo_cm_valid", bus.cm_valid, 1);
         chk("ooo_cm_idx",   bus.cm_idx,   i);
         chk("ooo_cm_rd",    bus.cm_rd,    i + 1);
         chk("ooo_cm_prd",   bus.cm_prd,   i + 40);
         chk("ooo_cm_prs",   bus.cm_prs,   i + 30);
         tick();
      end
      idle_inputs();
      chk("ooo_empty_count", bus.count,    0);
      chk("ooo_empty_valid", bus.cm_valid, 0);

      // Backpressure, then simultaneous dispatch and commit (head=tail=3)
      dispatch(7, 50, 51);
      tick();
      idle_inputs();
      writeback(3, 1'b0, 32'h0);
      tick();
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         chk("bp_cm_valid", bus.cm_valid, 1);
         chk("bp_cm_idx",   bus.cm_idx,   3);
         if (i < 2) tick();
      end
      bus.cm_ready = 1'b1;
      dispatch(8, 52, 53);
      tick();
      idle_inputs();
      chk("bp_both_count", bus.count,    1);
      chk("bp_both_head",  bus.cm_idx,   4);
      chk("bp_both_tail",  bus.disp_idx, 5);
      chk("bp_both_valid", bus.cm_valid, 0);

      // Mispredict flush
      do_reset();
      for (int i = 0; i < 4; i++) begin
         dispatch(i, i, i);
         tick();
      end
      idle_inputs();
      writeback(1, 1'b1, 32'h8000_0040);
      tick();
      writeback(0, 1'b0, 32'h0000_0100);
      tick();
      writeback(2, 1'b0, 32'h0000_0200);
      tick();
      writeback(3, 1'b0, 32'h0000_0300);
      tick();
      idle_inputs();
      chk("mp_cm0_valid", bus.cm_valid, 1);
      chk("mp_cm0_idx",   bus.cm_idx,   0);
      bus.cm_ready = 1'b1;
      tick();
      chk("mp_cm1_valid", bus.cm_valid, 1);
      chk("mp_cm1_idx",   bus.cm_idx,   1);
      chk("mp_pre_flush", bus.flush,    0);
      tick();
      chk("mp_flush",       bus.flush,      1);
      chk("mp_flush_npc",   bus.flush_npc,  32'h8000_0040);
      chk("mp_flush_valid", bus.cm_valid,   0);
      chk("mp_flush_ready", bus.disp_ready, 0);
      chk("mp_flush_count", bus.count,      0);
      dispatch(9, 9, 9);               // dropped: presented during flush
      writeback(2, 1'b0, 32'h0);
      tick();
      idle_inputs();
      bus.cm_ready = 1'b1;
      chk("mp_post_flush", bus.flush,    0);
      chk("mp_post_count", bus.count,    0);
      chk("mp_post_tail",  bus.disp_idx, 0);
      chk("mp_post_valid", bus.cm_valid, 0);
      tick();
      idle_inputs();
      chk("mp_post_valid2", bus.cm_valid, 0);

      // Wrap: 13 dispatch/writeback/commit rounds
      do_reset();
      for (int k = 0; k < 13; k++) begin
         chk("wrap_disp_idx", bus.disp_idx, k % 8);
         dispatch(k % 32, k, k + 1);
         tick();
         idle_inputs();
         writeback(k % 8, 1'b0, 32'h0);
         tick();
         idle_inputs();
         chk("wrap_cm_idx", bus.cm_idx,   k % 8);
         chk("wrap_cm_prs", bus.cm_prs,   k + 1);
         bus.cm_ready = 1'b1;
         tick();
         idle_inputs();
      end
      chk("wrap_tail",  bus.disp_idx, 5);
      chk("wrap_head",  bus.cm_idx,   5);
      chk("wrap_count", bus.count,    0);

      // Stale writeback to a committed slot while dispatching slot 5
      dispatch(1, 2, 3);
      writeback(4, 1'b0, 32'h0);
      tick();
      idle_inputs();
      chk("stale_wb_valid", bus.cm_valid, 0);
      chk("stale_wb_count", bus.count,    1);

      // Reset mid-fill is asynchronous
      dispatch(2, 3, 4);
      tick();
      dispatch(3, 4, 5);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_count",      bus.count,      0);
      chk("arst_disp_idx",   bus.disp_idx,   0);
      chk("arst_cm_idx",     bus.cm_idx,     0);
      chk("arst_disp_ready", bus.disp_ready, 1);
      chk("arst_cm_valid",   bus.cm_valid,   0);
      idle_inputs();
      tick();
      reset = 1'b0;
      tick();
      chk("arst_idle_count", bus.count, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
